alu_issue_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/regfile8x16.sv | 71 +++++++
 rtl/alu_issue_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and FSM state type for the ALU issue controller
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int ADDR_W = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLL = 3'd4;
    localparam logic [2:0] OP_SRL = 3'd5;
    localparam logic [2:0] OP_SRA = 3'd6;
    localparam logic [2:0] OP_SLA = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    // Only the adder ops produce a meaningful carry.
    function automatic logic op_has_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/regfile8x16.sv
// rtl/regfile8x16.sv - 8x16 register file, two read ports, debug port, load and writeback write ports (REG0_ZERO_EN)
module regfile8x16
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

`ifdef REG0_ZERO_EN
    localparam logic R0_ZERO = 1'b1;
`else
    localparam logic R0_ZERO = 1'b0;
`endif

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];
    logic              ld_we;
    logic              wb_we;

    assign ld_we = ld_en && !(R0_ZERO && (ld_addr == '0));
    assign wb_we = wb_en && !(R0_ZERO && (wb_addr == '0));

    // Next array contents: load first, writeback applied last so it wins on a same-address clash.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (ld_we) begin
            mem_d[ld_addr] = ld_data;
        end
        if (wb_we) begin
            mem_d[wb_addr] = wb_data;
        end
    end

    // Array storage, cleared while reset is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Combinational read ports; R0 is forced to zero when hardwired.
    always_comb begin
        rd1_data = mem_q[rd1_addr];
        rd2_data = mem_q[rd2_addr];
        dbg_data = mem_q[dbg_addr];
        if (R0_ZERO && (rd1_addr == '0)) rd1_data = '0;
        if (R0_ZERO && (rd2_addr == '0)) rd2_data = '0;
        if (R0_ZERO && (dbg_addr == '0)) dbg_data = '0;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - four-state issue controller feeding an external ALU/shifter (REG0_ZERO_EN)
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [3:0]        instr_shamt,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    output logic [3:0]        alu_shamt,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    output logic              done_valid,
    output logic [ADDR_W-1:0] done_rd,
    output logic [DATA_W-1:0] done_data,
    output logic              flag_z,
    output logic              flag_c,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t state_q, state_d;

    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] rs1_q, rs1_d;
    logic [ADDR_W-1:0] rs2_q, rs2_d;
    logic [3:0]        shamt_q, shamt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [3:0]        alu_shamt_q, alu_shamt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              carry_q, carry_d;
    logic              done_valid_q, done_valid_d;
    logic [ADDR_W-1:0] done_rd_q, done_rd_d;
    logic [DATA_W-1:0] done_data_q, done_data_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_c_q, flag_c_d;

    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic              accept;
    logic              wb_en;

    assign instr_ready = (state_q == IDLE) && rst_n;
    assign accept      = instr_valid && instr_ready;
    assign wb_en       = (state_q == WB);

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_shamt  = alu_shamt_q;
    assign alu_cin    = (alu_op_q == OP_SUB);
    assign done_valid = done_valid_q;
    assign done_rd    = done_rd_q;
    assign done_data  = done_data_q;
    assign flag_z     = flag_z_q;
    assign flag_c     = flag_c_q;

    regfile8x16 u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd1_addr (rs1_q),
        .rd1_data (rf_rd1),
        .rd2_addr (rs2_q),
        .rd2_data (rf_rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wb_en    (wb_en),
        .wb_addr  (rd_q),
        .wb_data  (result_q),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    // Next-state and per-stage datapath updates; every register holds unless its stage is active.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rd_d         = rd_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        shamt_d      = shamt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        alu_shamt_d  = alu_shamt_q;
        result_d     = result_q;
        carry_d      = carry_q;
        done_valid_d = 1'b0;
        done_rd_d    = done_rd_q;
        done_data_d  = done_data_q;
        flag_z_d     = flag_z_q;
        flag_c_d     = flag_c_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    rs1_d   = instr_rs1;
                    rs2_d   = instr_rs2;
                    shamt_d = instr_shamt;
                    state_d = READ;
                end
            end
            READ: begin
                alu_a_d     = rf_rd1;
                alu_b_d     = rf_rd2;
                alu_op_d    = op_q;
                alu_shamt_d = shamt_q;
                state_d     = EXEC;
            end
            EXEC: begin
                result_d = alu_result;
                carry_d  = op_has_carry(alu_op_q) ? alu_cout : 1'b0;
                state_d  = WB;
            end
            WB: begin
                done_valid_d = 1'b1;
                done_rd_d    = rd_q;
                done_data_d  = result_q;
                flag_z_d     = (result_q == '0);
                flag_c_d     = carry_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            shamt_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_shamt_q  <= '0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            done_valid_q <= 1'b0;
            done_rd_q    <= '0;
            done_data_q  <= '0;
            flag_z_q     <= 1'b0;
            flag_c_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            shamt_q      <= shamt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_shamt_q  <= alu_shamt_d;
            result_q     <= result_d;
            carry_q      <= carry_d;
            done_valid_q <= done_valid_d;
            done_rd_q    <= done_rd_d;
            done_data_q  <= done_data_d;
            flag_z_q     <= flag_z_d;
            flag_c_q     <= flag_c_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [2:0]  instr_rd;
    logic [2:0]  instr_rs1;
    logic [2:0]  instr_rs2;
    logic [3:0]  instr_shamt;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [3:0]  alu_shamt;
    logic        alu_cin;
    logic [15:0] alu_result;
    logic        alu_cout;
    logic        done_valid;
    logic [2:0]  done_rd;
    logic [15:0] done_data;
    logic        flag_z;
    logic        flag_c;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_shamt (instr_shamt),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_shamt   (alu_shamt),
        .alu_cin     (alu_cin),
        .alu_result  (alu_result),
        .alu_cout    (alu_cout),
        .done_valid  (done_valid),
        .done_rd     (done_rd),
        .done_data   (done_data),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Combinational ALU/shifter the controller drives.
    logic [16:0] sum;
    always_comb begin
        sum        = '0;
        alu_result = '0;
        alu_cout   = 1'b0;
        case (alu_op)
            3'd0: begin sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
                        alu_result = sum[15:0]; alu_cout = sum[16]; end
            3'd1: begin sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'd0, alu_cin};
                        alu_result = sum[15:0]; alu_cout = sum[16]; end
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a << alu_shamt;
            3'd5: alu_result = alu_a >> alu_shamt;
            3'd6: alu_result = $unsigned($signed(alu_a) >>> alu_shamt);
            default: alu_result = alu_a << alu_shamt;
        endcase
    end

    task automatic do_load(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic peek(input logic [2:0] a, output logic [15:0] d);
        dbg_addr = a; #1;
        d = dbg_data;
    endtask

    // Offers one instruction and reports how many edges after the accept edge done appeared (-1 if never).
    task automatic do_issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic [3:0] sh, output int lat,
                            output logic [15:0] data, output logic [2:0] drd,
                            output logic z, output logic c);
        int w;
        lat = -1; data = '0; drd = '0; z = 1'b0; c = 1'b0;
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_shamt = sh;
        instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!instr_ready) begin
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (done_valid) begin
                lat = i; data = done_data; drd = done_rd; z = flag_z; c = flag_c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [15:0] d;
        int nz;
        rst_n = 1'b0; instr_valid = 1'b0; ld_en = 1'b0;
        ld_addr = '0; ld_data = '0; dbg_addr = '0;
        instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low got=%b want=0", instr_ready); end
        rst_n = 1'b1; #1;
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_high got=%b want=1", instr_ready); end
        total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_valid); end
        total++; if ({alu_a, alu_b, alu_op, alu_shamt} !== 39'd0) begin bad++; $display("FAIL reset_alu_regs got=%h want=0", {alu_a, alu_b, alu_op, alu_shamt}); end
        total++; if ({flag_z, flag_c, done_rd, done_data} !== 21'd0) begin bad++; $display("FAIL reset_done_regs got=%h want=0", {flag_z, flag_c, done_rd, done_data}); end
        nz = 0;
        for (int i = 0; i < 8; i++) begin
            peek(i[2:0], d);
            if (d !== 16'h0) nz++;
        end
        total++; if (nz != 0) begin bad++; $display("FAIL reset_regs_nonzero got=%0d want=0", nz); end
    endtask

    task automatic test_add;
        int lat; logic [15:0] d, r; logic [2:0] drd; logic z, c;
        do_load(3'd1, 16'h0005);
        do_load(3'd2, 16'h0003);
        do_issue(3'd0, 3'd3, 3'd1, 3'd2, 4'd0, lat, d, drd, z, c);
        total++; if (lat != 3) begin bad++; $display("FAIL add_latency got=%0d want=3", lat); end
        total++; if ({drd, d, z, c} !== {3'd3, 16'h0008, 1'b0, 1'b0}) begin bad++; $display("FAIL add_done got=rd%0d %h z%b c%b want=rd3 0008 z0 c0", drd, d, z, c); end
        peek(3'd3, r);
        total++; if (r !== 16'h0008) begin bad++; $display("FAIL add_r3 got=%h want=0008", r); end
    endtask

    task automatic test_sub;
        int lat; logic [15:0] d, r; logic [2:0] drd; logic z, c;
        do_issue(3'd1, 3'd4, 3'd1, 3'd1, 4'd0, lat, d, drd, z, c);
        total++; if ({lat, d, z, c} !== {32'd3, 16'h0000, 1'b1, 1'b1}) begin bad++; $display("FAIL sub_self got=lat%0d %h z%b c%b want=lat3 0000 z1 c1", lat, d, z, c); end
        peek(3'd4, r);
        total++; if (r !== 16'h0000) begin bad++; $display("FAIL sub_r4 got=%h want=0000", r); end
        do_issue(3'd1, 3'd7, 3'd2, 3'd1, 4'd0, lat, d, drd, z, c);
        total++; if ({d, z, c} !== {16'hFFFE, 1'b0, 1'b0}) begin bad++; $display("FAIL sub_borrow got=%h z%b c%b want=fffe z0 c0", d, z, c); end
    endtask

    task automatic test_shift;
        int lat; logic [15:0] d, r; logic [2:0] drd; logic z, c;
        do_load(3'd5, 16'h8001);
        do_issue(3'd6, 3'd6, 3'd5, 3'd3, 4'd4, lat, d, drd, z, c);
        total++; if (d !== 16'hF800) begin bad++; $display("FAIL sra got=%h want=f800", d); end
        do_issue(3'd5, 3'd6, 3'd5, 3'd3, 4'd4, lat, d, drd, z, c);
        total++; if (d !== 16'h0800) begin bad++; $display("FAIL srl got=%h want=0800", d); end
        do_issue(3'd4, 3'd6, 3'd5, 3'd3, 4'd15, lat, d, drd, z, c);
        total++; if ({d, c} !== {16'h8000, 1'b0}) begin bad++; $display("FAIL sll got=%h c%b want=8000 c0", d, c); end
        do_issue(3'd7, 3'd6, 3'd1, 3'd3, 4'd2, lat, d, drd, z, c);
        total++; if (d !== 16'h0014) begin bad++; $display("FAIL sla got=%h want=0014", d); end
        peek(3'd6, r);
        total++; if (r !== 16'h0014) begin bad++; $display("FAIL shift_r6 got=%h want=0014", r); end
    endtask

    task automatic test_back_to_back;
        int ready_bad, dones;
        logic [15:0] r;
        @(posedge clk); #1;
        instr_op = 3'd0; instr_rd = 3'd7; instr_rs1 = 3'd1; instr_rs2 = 3'd2; instr_shamt = 4'd0;
        ready_bad = 0; dones = 0;
        for (int i = 0; i < 15; i++) begin
            instr_valid = (i < 10);
            if (i < 10 && instr_ready !== (i % 4 == 0)) ready_bad++;
            if (done_valid) dones++;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        total++; if (ready_bad != 0) begin bad++; $display("FAIL b2b_ready_pattern got=%0d wrong cycles want=0", ready_bad); end
        total++; if (dones != 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", dones); end
        peek(3'd7, r);
        total++; if (r !== 16'h0008) begin bad++; $display("FAIL b2b_r7 got=%h want=0008", r); end
    endtask

    // Issues rd=dst and places a load on the writeback edge.
    task automatic wb_with_load(input logic [2:0] dst, input logic [2:0] rs, input logic [2:0] la,
                                input logic [15:0] ld, output logic dv);
        int w;
        instr_op = 3'd0; instr_rd = dst; instr_rs1 = rs; instr_rs2 = rs; instr_shamt = 4'd0;
        instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ld_en = 1'b1; ld_addr = la; ld_data = ld;
        @(posedge clk); #1;
        ld_en = 1'b0;
        dv = done_valid;
    endtask

    task automatic test_ld_conflict;
        logic dv; logic [15:0] r;
        wb_with_load(3'd3, 3'd1, 3'd3, 16'h1234, dv);
        peek(3'd3, r);
        total++; if ({dv, r} !== {1'b1, 16'h000A}) begin bad++; $display("FAIL ld_same_rd got=dv%b %h want=dv1 000a", dv, r); end
        wb_with_load(3'd6, 3'd2, 3'd4, 16'hABCD, dv);
        peek(3'd6, r);
        total++; if (r !== 16'h0006) begin bad++; $display("FAIL ld_diff_wb got=%h want=0006", r); end
        peek(3'd4, r);
        total++; if (r !== 16'hABCD) begin bad++; $display("FAIL ld_diff_ld got=%h want=abcd", r); end
    endtask

    task automatic test_reset_mid;
        int w, dones, nz; logic [15:0] d;
        instr_op = 3'd0; instr_rd = 3'd5; instr_rs1 = 3'd1; instr_rs2 = 3'd2; instr_shamt = 4'd0;
        instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", instr_ready); end
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done_valid) dones++;
            @(posedge clk); #1;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL rst_mid_done got=%0d want=0", dones); end
        nz = 0;
        for (int i = 0; i < 8; i++) begin
            peek(i[2:0], d);
            if (d !== 16'h0) nz++;
        end
        total++; if (nz != 0) begin bad++; $display("FAIL rst_mid_regs got=%0d nonzero want=0", nz); end
    endtask

    task automatic test_reg0;
        int lat; logic [15:0] d, r; logic [2:0] drd; logic z, c;
        do_load(3'd0, 16'hFFFF);
        peek(3'd0, r);
`ifdef REG0_ZERO_EN
        total++; if (r !== 16'h0000) begin bad++; $display("FAIL r0_load got=%h want=0000", r); end
`else
        total++; if (r !== 16'hFFFF) begin bad++; $display("FAIL r0_load got=%h want=ffff", r); end
`endif
        do_load(3'd1, 16'h0002);
        do_issue(3'd0, 3'd0, 3'd1, 3'd1, 4'd0, lat, d, drd, z, c);
        total++; if ({lat, drd, d, z} !== {32'd3, 3'd0, 16'h0004, 1'b0}) begin bad++; $display("FAIL r0_wb_done got=lat%0d rd%0d %h z%b want=lat3 rd0 0004 z0", lat, drd, d, z); end
        peek(3'd0, r);
`ifdef REG0_ZERO_EN
        total++; if (r !== 16'h0000) begin bad++; $display("FAIL r0_wb got=%h want=0000", r); end
`else
        total++; if (r !== 16'h0004) begin bad++; $display("FAIL r0_wb got=%h want=0004", r); end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_back_to_back();
        test_ld_conflict();
        test_reset_mid();
        test_reg0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
